// File: rtl/dispatch_pkg.sv
// Shared types for the packet dispatch arbiter.
// Port identifiers and default queue-index width.
package dispatch_pkg;

  localparam int DEFAULT_QUEUES = 4;
  localparam int DEFAULT_QID_WIDTH = $clog2(DEFAULT_QUEUES);

  typedef logic [DEFAULT_QID_WIDTH-1:0] qid_t;

  typedef enum logic {
    PORT_1 = 1'b0,
    PORT_2 = 1'b1
  } port_t;

  localparam port_t RESET_LAST_GRANT = PORT_2;

endpackage

// File: rtl/rr_pick_2.sv
// Two-request round-robin picker.
// Pure combinational; last-grant state lives in the caller.
module rr_pick_2
  import dispatch_pkg::*;
(
  input  logic [1:0] elig,
  input  port_t      last,
  output logic [1:0] grant,
  output port_t      winner
);

  always_comb begin
    grant  = 2'b00;
    winner = last;
    unique case (1'b1)
      elig[0] && (!elig[1] || last == PORT_2): begin
        grant  = 2'b01;
        winner = PORT_1;
      end
      elig[1] && (!elig[0] || last == PORT_1): begin
        grant  = 2'b10;
        winner = PORT_2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// Shares the single queue write port between two packetizers.
// One-entry holding buffer per port, round-robin grant, registered write.
module dispatch_arbiter
  import dispatch_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int REGISTER_SIZE    = 32,
  localparam int QID_WIDTH       = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_SIZE-1:0]        packetizer_1_packet,
  input  logic                        packetizer_1_valid,
  input  logic [QID_WIDTH-1:0]        packetizer_1_id,
  output logic                        packetizer_1_ready,
  input  logic [DATA_SIZE-1:0]        packetizer_2_packet,
  input  logic                        packetizer_2_valid,
  input  logic [QID_WIDTH-1:0]        packetizer_2_id,
  output logic                        packetizer_2_ready,
  input  logic                        enable,
  input  logic [NUMBER_OF_QUEUES-1:0] queues_full,
  input  logic                        clear_counters,
  output logic [DATA_SIZE-1:0]        dispatcher_to_queues_packet,
  output logic [NUMBER_OF_QUEUES-1:0] dispatcher_to_queues_valid,
  output logic [REGISTER_SIZE-1:0]    accepted_count_1,
  output logic [REGISTER_SIZE-1:0]    accepted_count_2
);

  logic [1:0]           in_valid;
  logic [DATA_SIZE-1:0] in_packet [2];
  logic [QID_WIDTH-1:0] in_id [2];

  logic [1:0]           hold_valid;
  logic [DATA_SIZE-1:0] hold_packet [2];
  logic [QID_WIDTH-1:0] hold_id [2];

  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] ready;
  port_t      last_grant;
  port_t      winner;

  logic [DATA_SIZE-1:0]        sel_packet;
  logic [QID_WIDTH-1:0]        sel_id;
  logic [NUMBER_OF_QUEUES-1:0] sel_onehot;

  assign in_valid     = {packetizer_2_valid, packetizer_1_valid};
  assign in_packet[0] = packetizer_1_packet;
  assign in_packet[1] = packetizer_2_packet;
  assign in_id[0]     = packetizer_1_id;
  assign in_id[1]     = packetizer_2_id;

  // A queue just written is skipped: its full flag lags one write.
  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = enable && hold_valid[i]
             && !queues_full[hold_id[i]]
             && !dispatcher_to_queues_valid[hold_id[i]];
    end
  end

  rr_pick_2 u_pick (
    .elig   (elig),
    .last   (last_grant),
    .grant  (grant),
    .winner (winner)
  );

  assign ready              = ~hold_valid | grant;
  assign packetizer_1_ready = ready[0];
  assign packetizer_2_ready = ready[1];

  always_comb begin
    sel_packet = (winner == PORT_2) ? hold_packet[1] : hold_packet[0];
    sel_id     = (winner == PORT_2) ? hold_id[1] : hold_id[0];
    sel_onehot = '0;
    sel_onehot[sel_id] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        hold_packet[i] <= '0;
        hold_id[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && ready[i]) begin
          hold_valid[i]  <= 1'b1;
          hold_packet[i] <= in_packet[i];
          hold_id[i]     <= in_id[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dispatcher_to_queues_packet <= '0;
      dispatcher_to_queues_valid  <= '0;
      last_grant                  <= RESET_LAST_GRANT;
    end else if (|grant) begin
      dispatcher_to_queues_packet <= sel_packet;
      dispatcher_to_queues_valid  <= sel_onehot;
      last_grant                  <= winner;
    end else begin
      dispatcher_to_queues_valid <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accepted_count_1 <= '0;
      accepted_count_2 <= '0;
    end else if (clear_counters) begin
      accepted_count_1 <= '0;
      accepted_count_2 <= '0;
    end else begin
      if (grant[0]) accepted_count_1 <= accepted_count_1 + REGISTER_SIZE'(1);
      if (grant[1]) accepted_count_2 <= accepted_count_2 + REGISTER_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Self-checking bench for dispatch_arbiter.
// Directed vector table, hand sequences, then random traffic vs a model.
module tb_dispatch_arbiter;

  localparam int NQ = 4;
  localparam int DW = 678;
  localparam int RW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] p1_pkt = '0, p2_pkt = '0;
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [1:0]    p1_id = '0, p2_id = '0;
  logic          p1_r, p2_r;
  logic          en = 1'b0;
  logic [NQ-1:0] qf = '0;
  logic          clr = 1'b0;
  logic [DW-1:0] out_pkt;
  logic [NQ-1:0] out_v;
  logic [RW-1:0] c1, c2;

  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;

  dispatch_arbiter #(
    .NUMBER_OF_QUEUES (NQ),
    .DATA_SIZE        (DW),
    .REGISTER_SIZE    (RW)
  ) dut (
    .clock                       (clock),
    .reset                       (reset),
    .packetizer_1_packet         (p1_pkt),
    .packetizer_1_valid          (p1_v),
    .packetizer_1_id             (p1_id),
    .packetizer_1_ready          (p1_r),
    .packetizer_2_packet         (p2_pkt),
    .packetizer_2_valid          (p2_v),
    .packetizer_2_id             (p2_id),
    .packetizer_2_ready          (p2_r),
    .enable                      (en),
    .queues_full                 (qf),
    .clear_counters              (clr),
    .dispatcher_to_queues_packet (out_pkt),
    .dispatcher_to_queues_valid  (out_v),
    .accepted_count_1            (c1),
    .accepted_count_2            (c2)
  );

  // Reference model: each port holds at most one pending packet,
  // the output is a queue number (-1 = idle), winners tracked as 1/2.
  bit            m_hv [2];
  logic [DW-1:0] m_hp [2];
  int            m_hid [2];
  int            m_last;
  int            m_oq;
  logic [DW-1:0] m_opkt;
  logic [RW-1:0] m_cnt [2];
  int            m_g;
  bit            m_rdy [2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_pkt(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_hv[p]  = 1'b0;
      m_hp[p]  = '0;
      m_hid[p] = 0;
      m_cnt[p] = '0;
      m_rdy[p] = 1'b1;
    end
    m_last = 2;
    m_oq   = -1;
    m_opkt = '0;
    m_g    = 0;
  endfunction

  function automatic void model_eval();
    bit e [2];
    for (int p = 0; p < 2; p++)
      e[p] = en && m_hv[p] && !qf[m_hid[p]] && (m_oq != m_hid[p]);
    if (e[0] && e[1]) m_g = (m_last == 1) ? 2 : 1;
    else if (e[0])    m_g = 1;
    else if (e[1])    m_g = 2;
    else              m_g = 0;
    for (int p = 0; p < 2; p++)
      m_rdy[p] = !m_hv[p] || (m_g == p + 1);
  endfunction

  function automatic void model_edge();
    bit            v [2];
    int            id [2];
    logic [DW-1:0] pk [2];
    v[0] = p1_v;  id[0] = int'(p1_id); pk[0] = p1_pkt;
    v[1] = p2_v;  id[1] = int'(p2_id); pk[1] = p2_pkt;
    if (m_g != 0) begin
      m_oq   = m_hid[m_g-1];
      m_opkt = m_hp[m_g-1];
      m_last = m_g;
      m_cnt[m_g-1] = m_cnt[m_g-1] + 1;
    end else begin
      m_oq = -1;
    end
    if (clr) begin
      m_cnt[0] = '0;
      m_cnt[1] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      if (v[p] && m_rdy[p]) begin
        m_hv[p]  = 1'b1;
        m_hp[p]  = pk[p];
        m_hid[p] = id[p];
      end else if (m_g == p + 1) begin
        m_hv[p] = 1'b0;
      end
    end
  endfunction

  function automatic logic [DW-1:0] rand_pkt();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 22; i++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction

  // Called just after a falling edge: drive, settle, compare to model.
  task automatic drive(input bit v1, input int id1, input bit v2,
                       input int id2, input bit e,
                       input logic [NQ-1:0] q, input bit c);
    logic [NQ-1:0] ev;
    p1_v = v1; p1_id = 2'(id1); p1_pkt = rand_pkt();
    p2_v = v2; p2_id = 2'(id2); p2_pkt = rand_pkt();
    en = e; qf = q; clr = c;
    #1;
    model_eval();
    ev = (m_oq < 0) ? '0 : (NQ'(1) << m_oq);
    chk("out_valid", 32'(out_v), 32'(ev));
    chk_pkt("out_packet", out_pkt, m_opkt);
    chk("ready_1", 32'(p1_r), 32'(m_rdy[0]));
    chk("ready_2", 32'(p2_r), 32'(m_rdy[1]));
    chk("count_1", c1, m_cnt[0]);
    chk("count_2", c2, m_cnt[1]);
  endtask

  task automatic advance();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  typedef struct {
    bit            v1;
    int            id1;
    bit            v2;
    int            id2;
    bit            en;
    logic [NQ-1:0] qf;
    logic [NQ-1:0] ev;
    bit            r1;
    bit            r2;
    int            c1;
    int            c2;
  } vec_t;

  vec_t tbl [23];

  initial begin
    // single packet, same-queue pair, full queue, enable off
    tbl[0]  = '{1,2,0,0,1,4'b0000, 4'b0000,1,1,0,0};
    tbl[1]  = '{0,0,0,0,1,4'b0000, 4'b0000,1,1,0,0};
    tbl[2]  = '{0,0,0,0,1,4'b0000, 4'b0100,1,1,1,0};
    tbl[3]  = '{1,3,1,3,1,4'b0000, 4'b0000,1,1,1,0};
    tbl[4]  = '{1,3,1,3,1,4'b0000, 4'b0000,0,1,1,0};
    tbl[5]  = '{1,3,1,3,1,4'b0000, 4'b1000,0,0,1,1};
    tbl[6]  = '{1,3,1,3,1,4'b0000, 4'b0000,1,0,1,1};
    tbl[7]  = '{1,3,1,3,1,4'b0000, 4'b1000,0,0,2,1};
    tbl[8]  = '{0,3,0,3,1,4'b0000, 4'b0000,0,1,2,1};
    tbl[9]  = '{0,3,0,3,1,4'b0000, 4'b1000,0,1,2,2};
    tbl[10] = '{0,3,0,3,1,4'b0000, 4'b0000,1,1,2,2};
    tbl[11] = '{0,3,0,3,1,4'b0000, 4'b1000,1,1,3,2};
    tbl[12] = '{1,1,1,0,1,4'b0010, 4'b0000,1,1,3,2};
    tbl[13] = '{0,1,1,0,1,4'b0010, 4'b0000,0,1,3,2};
    tbl[14] = '{0,1,0,0,1,4'b0010, 4'b0001,0,0,3,3};
    tbl[15] = '{0,1,0,0,1,4'b0010, 4'b0000,0,1,3,3};
    tbl[16] = '{0,1,0,0,1,4'b0000, 4'b0001,1,1,3,4};
    tbl[17] = '{0,1,0,0,1,4'b0000, 4'b0010,1,1,4,4};
    tbl[18] = '{1,0,1,1,0,4'b0000, 4'b0000,1,1,4,4};
    tbl[19] = '{1,0,1,1,0,4'b0000, 4'b0000,0,0,4,4};
    tbl[20] = '{0,0,0,1,1,4'b0000, 4'b0000,0,1,4,4};
    tbl[21] = '{0,0,0,1,1,4'b0000, 4'b0010,1,1,4,5};
    tbl[22] = '{0,0,0,1,1,4'b0000, 4'b0001,1,1,5,5};

    model_reset();
    @(negedge clock);
    drive(0, 0, 0, 0, 1, '0, 0);
    reset = 1'b1;
    advance();

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].v1, tbl[i].id1, tbl[i].v2, tbl[i].id2,
            tbl[i].en, tbl[i].qf, 0);
      chk($sformatf("tbl%0d_valid", i), 32'(out_v), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready_1", i), 32'(p1_r), 32'(tbl[i].r1));
      chk($sformatf("tbl%0d_ready_2", i), 32'(p2_r), 32'(tbl[i].r2));
      chk($sformatf("tbl%0d_count_1", i), c1, 32'(tbl[i].c1));
      chk($sformatf("tbl%0d_count_2", i), c2, 32'(tbl[i].c2));
      advance();
    end

    // asynchronous reset with both buffers full and a write registered
    drive(1, 0, 1, 1, 1, '0, 0);
    advance();
    drive(1, 2, 1, 3, 1, '0, 0);
    advance();
    drive(0, 0, 0, 0, 1, '0, 0);
    chk("pre_reset_busy", 32'(out_v != '0), 32'(1));
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(out_v), 32'(0));
    chk("rst_ready_1", 32'(p1_r), 32'(1));
    chk("rst_ready_2", 32'(p2_r), 32'(1));
    chk("rst_count_1", c1, 32'(0));
    chk("rst_count_2", c2, 32'(0));
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, '0, 0);
      chk("post_reset_idle", 32'(out_v), 32'(0));
      advance();
    end

    // enable low buffers without granting; port 1 wins first after reset
    drive(1, 0, 1, 1, 0, '0, 0);
    chk("en_off_ready", 32'({p1_r, p2_r}), 32'(2'b11));
    advance();
    drive(1, 0, 1, 1, 0, '0, 0);
    chk("en_off_stall", 32'({p1_r, p2_r}), 32'(2'b00));
    advance();
    drive(0, 0, 0, 0, 1, '0, 1);
    chk("en_on_grant_1", 32'({p1_r, p2_r}), 32'(2'b10));
    advance();
    drive(0, 0, 0, 0, 1, '0, 0);
    chk("first_write_q0", 32'(out_v), 32'(4'b0001));
    chk("clear_beats_inc", c1, 32'(0));
    advance();
    drive(0, 0, 0, 0, 1, '0, 0);
    chk("second_write_q1", 32'(out_v), 32'(4'b0010));
    chk("count_2_after", c2, 32'(1));
    advance();

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, int'($urandom_range(3, 0)),
            ($urandom % 4) != 0, int'($urandom_range(3, 0)),
            ($urandom % 8) != 0,
            NQ'($urandom & $urandom & $urandom),
            ($urandom % 64) == 0);
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
